// File: rtl/ring_ctr_pkg.sv
// ring_ctr_pkg: shared mode encodings and seed helper for ring/Johnson sequencers
package ring_ctr_pkg;
    localparam logic [1:0] MODE_RING = 2'b00;
    localparam logic [1:0] MODE_JOHNSON = 2'b01;
    localparam int MAX_W = 1024;
    function automatic logic [MAX_W-1:0] seed_of(input logic [1:0] mode, input int width);
        seed_of = (mode == MODE_JOHNSON) ? '0 : MAX_W'(1) << (width - 1);
    endfunction
endpackage

// File: rtl/ring_state_check.sv
// ring_state_check: flags whether count is a reachable state of the selected sequence
module ring_state_check
    import ring_ctr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] count,
    input  logic [1:0]       mode,
    output logic             legal
);
    logic ring_ok, john_ok;
    assign ring_ok = $countones(count) == 1;
    // a Johnson state has at most one 0/1 boundary between neighbouring bits
    assign john_ok = $countones(count[WIDTH-1:1] ^ count[WIDTH-2:0]) <= 1;
    assign legal = mode == MODE_RING ? ring_ok : mode == MODE_JOHNSON ? john_ok : 1'b1;
endmodule

// File: rtl/param_ring_counter.sv
// param_ring_counter: ring/Johnson counter with load, direction, wrap pulse and self-correction
module param_ring_counter
    import ring_ctr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter bit SELF_CORRECT = 1
) (
    input  logic             clk,
    input  logic             init,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             illegal
);
    logic [WIDTH-1:0] seed, rot, count_n;
    logic legal, twist, active, wrap_n, illegal_n;
    assign seed = WIDTH'(seed_of(mode, WIDTH));
    assign twist = mode == MODE_JOHNSON;
    assign active = mode == MODE_RING || mode == MODE_JOHNSON;
    assign rot = dir ? {count[0] ^ twist, count[WIDTH-1:1]} : {count[WIDTH-2:0], count[WIDTH-1] ^ twist};
    ring_state_check #(.WIDTH(WIDTH)) u_check (
        .count(count),
        .mode (mode),
        .legal(legal)
    );
    always_comb begin
        count_n = count;
        wrap_n = 1'b0;
        illegal_n = 1'b0;
        if (init) count_n = seed;
        else if (load) count_n = load_val;
        else if (en && active) begin
            if (SELF_CORRECT && !legal) begin
                count_n = seed;
                illegal_n = 1'b1;
            end else begin
                count_n = rot;
                wrap_n = rot == seed;
            end
        end
    end
    always_ff @(posedge clk) begin
        count <= count_n;
        wrap <= wrap_n;
        illegal <= illegal_n;
    end
endmodule
